mult_dispatcher: RTL and testbench

Upstream issue stage for the sequential shift-add `multiplier`. It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. It issues each pair to the multiplier with a one-cycle `start` pulse, waits for `ready`, and presents the captured product on a valid/ready output. It lets producers stream operands without tracking the multiplier's N-cycle busy window.

---
 rtl/mult_dispatcher_if.sv | 50 +++++
 rtl/mult_dispatcher.sv | 165 ++++++++++++++++
 tb/tb_mult_dispatcher.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_dispatcher_if
// Description : Bundle of every handshake and data signal around the
//               mult_dispatcher: operand input stream, multiplier
//               start/operands/product/ready, and result output stream.
//               slave  - seen from the dispatcher
//               master - seen from the surrounding environment
//                        (producer, multiplier, consumer)
// Parameters  : N - operand width, product is 2N bits
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_dispatcher_if #(
    parameter int N = 4
);
    // operand stream
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    // multiplier side
    logic             mul_start;
    logic [N-1:0]     mul_multiplicand;
    logic [N-1:0]     mul_multiplier;
    logic [2*N-1:0]   mul_product;
    logic             mul_ready;
    // result stream
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_product;

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready,
        output mul_start, mul_multiplicand, mul_multiplier,
        input  mul_product, mul_ready,
        output out_valid, out_product,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready,
        input  mul_start, mul_multiplicand, mul_multiplier,
        output mul_product, mul_ready,
        input  out_valid, out_product,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/mult_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : mult_dispatcher
// Description : Issue stage for a sequential shift-add multiplier. Operand
//               pairs are queued in a DEPTH-entry FIFO, issued one at a time
//               with a single-cycle start pulse, and the product is held in
//               an output register until the consumer accepts it.
// Ports       : clock   - rising-edge clock
//               n_reset - asynchronous active-low reset
//               bus     - mult_dispatcher_if.slave:
//                           in_valid/in_ready/in_a/in_b        operand stream
//                           mul_start/mul_multiplicand/
//                           mul_multiplier/mul_product/mul_ready multiplier
//                           out_valid/out_ready/out_product    result stream
// Parameters  : N     - operand width (must match the multiplier)
//               DEPTH - FIFO entries, power of two, >= 2
// Options     : MULT_DISPATCH_ZERO_BYPASS_EN - when defined, a head entry with
//               a zero operand is retired directly as product 0 without
//               using the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_dispatcher #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input wire          clock,
    input wire          n_reset,
    mult_dispatcher_if.slave bus
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(DEPTH);

    // Bit 0 is set only in ISSUE so mul_start comes straight off a flop.
    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_ISSUE = 2'b01;
    localparam logic [1:0] c_WAIT  = 2'b10;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic [N-1:0]        r_mem_a [DEPTH];
    logic [N-1:0]        r_mem_b [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;

    logic [N-1:0]        r_op_a;
    logic [N-1:0]        r_op_b;
    logic                r_out_valid;
    logic [2*N-1:0]      r_out_product;

    logic                w_push;
    logic                w_empty;
    logic                w_out_free;
    logic                w_bypass;
    logic                w_take_head;
    logic                w_pop;
    logic                w_issue_load;
    logic                w_capture;
    logic                w_zero_capture;

    assign w_empty    = (r_count == '0);
    assign w_push     = bus.in_valid && bus.in_ready;
    // Issue only when the output register is empty or being emptied, so a
    // capture can never overwrite an unaccepted result.
    assign w_out_free = !r_out_valid || bus.out_ready;

`ifdef MULT_DISPATCH_ZERO_BYPASS_EN
    assign w_bypass = (r_mem_a[r_rd_ptr] == '0) || (r_mem_b[r_rd_ptr] == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_take_head = (r_state == c_IDLE) && !w_empty && w_out_free;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_take_head && !w_bypass) w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = c_WAIT;
            c_WAIT:  if (bus.mul_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_pop          = w_take_head;
        w_issue_load   = w_take_head && !w_bypass;
        w_zero_capture = w_take_head && w_bypass;
        w_capture      = (r_state == c_WAIT) && bus.mul_ready;
    end

    assign bus.mul_start        = r_state[0];
    assign bus.mul_multiplicand = r_op_a;
    assign bus.mul_multiplier   = r_op_b;
    assign bus.in_ready         = (r_count != c_FULL);
    assign bus.out_valid        = r_out_valid;
    assign bus.out_product      = r_out_product;

    // ----------------------------------------------------------------- FIFO
    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.in_a;
            r_mem_b[r_wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------ operand holding
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_issue_load) begin
            r_op_a <= r_mem_a[r_rd_ptr];
            r_op_b <= r_mem_b[r_rd_ptr];
        end
    end

    // ------------------------------------------------------ result register
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_out_valid   <= 1'b0;
            r_out_product <= '0;
        end else if (w_capture) begin
            r_out_valid   <= 1'b1;
            r_out_product <= bus.mul_product;
        end else if (w_zero_capture) begin
            r_out_valid   <= 1'b1;
            r_out_product <= '0;
        end else if (bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_dispatcher
// Description : Self-checking bench for mult_dispatcher. Contains a
//               behavioural model of the shift-add multiplier (ready drops
//               after the start edge, rises N edges later), a monitor that
//               logs accepted operands as expected products (a*b) and
//               accepted results, and one task per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mult_dispatcher;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int PW    = 2 * N;

    logic clock   = 1'b0;
    logic n_reset = 1'b0;
    always #5 clock = ~clock;

    mult_dispatcher_if #(.N(N)) bus ();

    mult_dispatcher #(.N(N), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];

    // ------------------------------------------------- multiplier model
    logic [N-1:0] m_a, m_b;
    logic         m_busy;
    int           m_cnt;
    always @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            bus.mul_ready   <= 1'b1;
            bus.mul_product <= '0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
        end else if (m_busy) begin
            if (m_cnt == N) begin
                bus.mul_ready   <= 1'b1;
                bus.mul_product <= PW'(int'(m_a) * int'(m_b));
                m_busy          <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (bus.mul_start) begin
            m_a           <= bus.mul_multiplicand;
            m_b           <= bus.mul_multiplier;
            m_busy        <= 1'b1;
            m_cnt         <= 1;
            bus.mul_ready <= 1'b0;
        end
    end

    // ------------------------------------------- reference model / monitor
    // Inputs only change just after a rising edge, so a handshake seen at
    // the falling edge is the one that completes at the next rising edge.
    always @(negedge clock) begin
        if (!n_reset) begin
            exp_q.delete();
            got_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(PW'(int'(bus.in_a) * int'(bus.in_b)));
            if (bus.out_valid && bus.out_ready)
                got_q.push_back(bus.out_product);
            if (bus.mul_start)
                start_cnt++;
        end
    end

    // ---------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_pair(input logic [N-1:0] a, input logic [N-1:0] b);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clock);
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (t >= 200) $display("FAIL push_timeout: in_ready=%b, required 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.out_ready = 1'b1;
        while ((got_q.size() < exp_q.size() || bus.out_valid) && t < 500) begin
            tick();
            t++;
        end
        repeat (3) tick();
        n_checks++;
        if (t >= 500) $display("FAIL drain_timeout: got %0d results, required %0d", got_q.size(), exp_q.size());
        else n_pass++;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks += 6;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); else n_pass++;
        if (bus.mul_start !== 1'b0) $display("FAIL reset_mul_start: got %b required 0", bus.mul_start); else n_pass++;
        if (bus.mul_multiplicand !== '0) $display("FAIL reset_multiplicand: got %0d required 0", bus.mul_multiplicand); else n_pass++;
        if (bus.mul_multiplier !== '0) $display("FAIL reset_multiplier: got %0d required 0", bus.mul_multiplier); else n_pass++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); else n_pass++;
        if (bus.out_product !== '0) $display("FAIL reset_out_product: got %0d required 0", bus.out_product); else n_pass++;
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        push_pair(4'd11, 4'd6);               // returns just after E0
        for (int k = 1; k <= 8; k++) begin
            tick();                           // just after Ek
            n_checks += 2;
            if (bus.mul_start !== (k == 1)) $display("FAIL single_start_E%0d: got %b required %b", k, bus.mul_start, (k == 1)); else n_pass++;
            if (bus.out_valid !== (k == 7)) $display("FAIL single_valid_E%0d: got %b required %b", k, bus.out_valid, (k == 7)); else n_pass++;
            if (k == 1) begin
                n_checks += 2;
                if (bus.mul_multiplicand !== 4'd11) $display("FAIL single_mcand: got %0d required 11", bus.mul_multiplicand); else n_pass++;
                if (bus.mul_multiplier !== 4'd6) $display("FAIL single_mplier: got %0d required 6", bus.mul_multiplier); else n_pass++;
            end
            if (k == 7) begin
                n_checks++;
                if (bus.out_product !== 8'd66) $display("FAIL single_product: got %0d required 66", bus.out_product); else n_pass++;
            end
        end
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL single_count: got %0d required %0d", got_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL single_sb[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] pa [5];
        logic [N-1:0] pb [5];
        int t;
        pa = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd15};
        pb = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd15};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_pair(pa[i], pb[i]);
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 30) begin tick(); t++; end
        repeat (5) tick();
        n_checks += 3;
        if (bus.out_valid !== 1'b1) $display("FAIL bp_held_valid: got %b required 1", bus.out_valid); else n_pass++;
        if (bus.out_product !== 8'd6) $display("FAIL bp_held_product: got %0d required 6", bus.out_product); else n_pass++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b required 0", bus.in_ready); else n_pass++;
        drain();
        n_checks++;
        if (got_q.size() !== 5) $display("FAIL bp_count: got %0d required 5", got_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL bp_sb[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_wrap();
        fork
            begin
                for (int i = 1; i <= 10; i++)
                    push_pair(N'(i % 16), N'((i + 1) % 16));
            end
            begin
                repeat (80) begin
                    tick();
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (got_q.size() !== 10) $display("FAIL wrap_count: got %0d required 10", got_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL wrap_sb[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push_pair(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
                end
            end
            begin
                repeat (150) begin
                    tick();
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (got_q.size() !== 20) $display("FAIL rand_count: got %0d required 20", got_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rand_sb[%0d]: got %0d required %0d", i, got_q[i], exp_q[i]); else n_pass++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_wait();
        int seen_valid;
        bus.out_ready = 1'b1;
        push_pair(4'd5, 4'd5);                // E0
        push_pair(4'd6, 4'd6);                // E1: first pair issued
        push_pair(4'd7, 4'd7);                // E2: multiplier started, WAIT
        push_pair(4'd3, 4'd2);                // E3: three entries queued
        n_reset = 1'b0;
        #1;
        n_checks += 3;
        if (bus.out_valid !== 1'b0) $display("FAIL rstw_out_valid: got %b required 0", bus.out_valid); else n_pass++;
        if (bus.in_ready !== 1'b1) $display("FAIL rstw_in_ready: got %b required 1", bus.in_ready); else n_pass++;
        if (bus.mul_multiplicand !== '0) $display("FAIL rstw_mcand: got %0d required 0", bus.mul_multiplicand); else n_pass++;
        @(negedge clock);
        tick();
        n_reset = 1'b1;
        seen_valid = 0;
        repeat (15) begin
            tick();
            if (bus.out_valid === 1'b1) seen_valid++;
        end
        n_checks++;
        if (seen_valid !== 0) $display("FAIL rstw_no_result: out_valid seen %0d cycles, required 0", seen_valid); else n_pass++;
        push_pair(4'd3, 4'd3);
        drain();
        n_checks += 2;
        if (got_q.size() !== 1) $display("FAIL rstw_count: got %0d required 1", got_q.size()); else n_pass++;
        if (got_q.size() > 0 && got_q[0] !== exp_q[0]) $display("FAIL rstw_product: got %0d required %0d", got_q[0], exp_q[0]); else n_pass++;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_zero();
        int s0;
        int vk;
        bit byp;
`ifdef MULT_DISPATCH_ZERO_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        vk = byp ? 1 : 7;
        bus.out_ready = 1'b1;
        s0 = start_cnt;
        push_pair(4'd0, 4'd9);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== (k == vk)) $display("FAIL zero_valid_E%0d: got %b required %b", k, bus.out_valid, (k == vk)); else n_pass++;
            if (k == vk) begin
                n_checks++;
                if (bus.out_product !== '0) $display("FAIL zero_product: got %0d required 0", bus.out_product); else n_pass++;
            end
        end
        n_checks++;
        if ((start_cnt - s0) !== (byp ? 0 : 1)) $display("FAIL zero_starts: got %0d required %0d", start_cnt - s0, byp ? 0 : 1); else n_pass++;
        drain();
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_reset_wait();
        test_zero();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
